// File: rtl/mult_div_unit.sv
// Sequential signed Booth multiply / restoring divide with HI/LO result.
// Divide datapath is built only when MULTDIV_DIV_EN is defined.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_n;

  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   acc;
  logic [WIDTH:0]   m;
  logic [WIDTH-1:0] q;
  logic             q1;

  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   acc_n;
  logic [WIDTH-1:0] q_n;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;
  logic             go_done;

`ifdef MULTDIV_DIV_EN
  logic             op_r;
  logic             neg_q;
  logic             neg_r;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  assign abs_a   = a[WIDTH-1] ? -a : a;
  assign abs_b   = b[WIDTH-1] ? -b : b;
  assign go_done = op && (b == '0);
`else
  assign go_done = op;
`endif

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = go_done ? DONE : RUN;
        end
      end
      RUN: begin
        if (cnt == CW'(1)) begin
          state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // One iteration; the extra acc bit keeps -2^(W-1) multiplicands exact.
  always_comb begin
    unique case ({q[0], q1})
      2'b01:   booth_sum = acc + m;
      2'b10:   booth_sum = acc - m;
      default: booth_sum = acc;
    endcase
    acc_n  = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
    q_n    = {booth_sum[0], q[WIDTH-1:1]};
    res_hi = acc_n[WIDTH-1:0];
    res_lo = q_n;
`ifdef MULTDIV_DIV_EN
    shifted = {acc[WIDTH-1:0], q[WIDTH-1]};
    trial   = shifted - m;
    if (op_r) begin
      if (trial[WIDTH]) begin
        acc_n = shifted;
        q_n   = {q[WIDTH-2:0], 1'b0};
      end else begin
        acc_n = trial;
        q_n   = {q[WIDTH-2:0], 1'b1};
      end
      res_hi = neg_r ? -acc_n[WIDTH-1:0] : acc_n[WIDTH-1:0];
      res_lo = neg_q ? -q_n : q_n;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      acc <= '0;
      m   <= '0;
      q   <= '0;
      q1  <= 1'b0;
      hi  <= '0;
      lo  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start && state_n == RUN) begin
            cnt <= CW'(WIDTH);
            acc <= '0;
            q1  <= 1'b0;
`ifdef MULTDIV_DIV_EN
            if (op) begin
              m <= {1'b0, abs_b};
              q <= abs_a;
            end else begin
              m <= {a[WIDTH-1], a};
              q <= b;
            end
`else
            m <= {a[WIDTH-1], a};
            q <= b;
`endif
          end
        end
        RUN: begin
          acc <= acc_n;
          q   <= q_n;
          q1  <= q[0];
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            hi <= res_hi;
            lo <= res_lo;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef MULTDIV_DIV_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      op_r     <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
    end else if (state == IDLE && start) begin
      op_r     <= op;
      neg_q    <= a[WIDTH-1] ^ b[WIDTH-1];
      neg_r    <= a[WIDTH-1];
      div_zero <= go_done;
    end
  end
`else
  assign div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed mult/div vectors,
// div-by-zero, start-while-busy and reset-mid-operation cases.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_zero;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .op(op),
    .a(a),
    .b(b),
    .busy(busy),
    .done(done),
    .hi(hi),
    .lo(lo),
    .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
    int          nbusy;
    int          t;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   busy_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done at cycle %0d", cyc);
        end else begin
          e = sbq.pop_front();
          chk("hi", hi, e.hi);
          chk("lo", lo, e.lo);
          chk("div_zero", 32'(div_zero), 32'(e.dz));
          chk("latency", 32'(cyc - e.t), 32'(e.lat));
          chk("busy_cycles", 32'(busy_cnt), 32'(e.nbusy));
          chk("busy_at_done", 32'(busy), 32'd0);
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic issue(input logic o, input logic [31:0] x,
                       input logic [31:0] y, input logic push,
                       input logic [31:0] eh, input logic [31:0] el,
                       input logic ed, input int lat, input int nb);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    if (push) begin
      e.hi    = eh;
      e.lo    = el;
      e.dz    = ed;
      e.lat   = lat;
      e.nbusy = nb;
      e.t     = cyc;
      sbq.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic mult(input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] eh, input logic [31:0] el);
    issue(1'b0, x, y, 1'b1, eh, el, 1'b0, 33, 32);
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (sbq.size() == 0) break;
      @(negedge clk);
    end
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: %0d results outstanding", sbq.size());
      sbq.delete();
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic seen;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dz", 32'(div_zero), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);

    mult(32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    drain();
    mult(32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
    drain();
    mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1);
    drain();
    mult(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h1);
    drain();

    // start pulsed while busy must be ignored
    mult(32'h1234_5678, 32'h10, 32'h1, 32'h2345_6780);
    repeat (3) @(negedge clk);
    start = 1'b1;
    a     = 32'h5;
    b     = 32'h5;
    @(negedge clk);
    start = 1'b0;
    drain();

`ifdef MULTDIV_DIV_EN
    issue(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1,
          32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33, 32);
    drain();
    issue(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b1,
          32'h1, 32'hFFFF_FFFD, 1'b0, 33, 32);
    drain();
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1,
          32'h0, 32'h8000_0000, 1'b0, 33, 32);
    drain();
    issue(1'b1, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14, 1'b0, 33, 32);
    drain();
    issue(1'b1, 32'h3412, 32'h100, 1'b1, 32'h12, 32'h34, 1'b0, 33, 32);
    drain();
    issue(1'b1, 32'd55, 32'd0, 1'b1, 32'h12, 32'h34, 1'b1, 1, 0);
    drain();
    chk("dz_held", 32'(div_zero), 32'd1);
    mult(32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    chk("dz_cleared", 32'(div_zero), 32'd0);
    drain();
`else
    issue(1'b1, 32'd9, 32'd3, 1'b1, 32'h1, 32'h2345_6780, 1'b0, 1, 0);
    drain();
    mult(32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    drain();
`endif

    // reset in the middle of a run discards the result
    issue(1'b0, 32'd3, 32'd5, 1'b0, 32'h0, 32'h0, 1'b0, 0, 0);
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) seen = 1'b1;
      @(negedge clk);
    end
    chk("midrst_no_done", 32'(seen), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
